// File: rtl/cpu_bank_reg_mp_if.sv
// Bundle between decode / write-back stages and the multi-port register bank.
// The master side is the pipeline; the slave side is the bank.
interface cpu_bank_reg_mp_if #(
  parameter int NUM_REGS  = 32,
  parameter int REG_WIDTH = 32,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 2
);
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_RD*AW-1:0]        rd_addr;
  logic [NUM_RD*REG_WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]           rd_pending;
  logic [NUM_WR-1:0]           wr_en;
  logic [NUM_WR*AW-1:0]        wr_addr;
  logic [NUM_WR*REG_WIDTH-1:0] wr_data;
  logic                        res_en;
  logic [AW-1:0]               res_addr;
  logic                        wr_collision;
  logic                        pending_any;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, res_en, res_addr,
    input  rd_data, rd_pending, wr_collision, pending_any
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, res_en, res_addr,
    output rd_data, rd_pending, wr_collision, pending_any
  );
endinterface

// File: rtl/cpu_bank_reg_mp.sv
// Multi-port register bank with highest-port-wins write priority, optional
// write-to-read bypass and a per-register pending (reservation) scoreboard.
module cpu_bank_reg_mp #(
  parameter int NUM_REGS  = 32,
  parameter int REG_WIDTH = 32,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 2,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  cpu_bank_reg_mp_if.slave   bus
);
  localparam int AW = $clog2(NUM_REGS);

  logic [REG_WIDTH-1:0]        regs [NUM_REGS];
  logic [NUM_REGS-1:0]         pending;
  logic                        collision_p1;

  logic [NUM_REGS-1:0]         wr_hit;
  logic [NUM_REGS-1:0]         wr_multi;
  logic [NUM_REGS-1:0]         res_hit;
  logic [REG_WIDTH-1:0]        wr_win [NUM_REGS];

  logic [NUM_RD*REG_WIDTH-1:0] rd_data_c;
  logic [NUM_RD-1:0]           rd_pend_c;
  logic [AW-1:0]               ra;

  // Per-register write resolution; ports scanned upward so the highest enabled
  // port wins. Requests are gated by rst_n so nothing bypasses during reset.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      wr_hit[r]   = 1'b0;
      wr_multi[r] = 1'b0;
      wr_win[r]   = '0;
      res_hit[r]  = rst_n && bus.res_en && (bus.res_addr == AW'(r));
      for (int p = 0; p < NUM_WR; p++) begin
        if (rst_n && bus.wr_en[p] && (bus.wr_addr[p*AW +: AW] == AW'(r))) begin
          wr_multi[r] = wr_multi[r] | wr_hit[r];
          wr_hit[r]   = 1'b1;
          wr_win[r]   = bus.wr_data[p*REG_WIDTH +: REG_WIDTH];
        end
      end
      if ((ZERO_REG != 0) && (r == 0)) begin
        wr_hit[r]   = 1'b0;
        wr_multi[r] = 1'b0;
        res_hit[r]  = 1'b0;
      end
    end
  end

  // ---- stage boundary: array, scoreboard and collision flag commit ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
      pending      <= '0;
      collision_p1 <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_hit[r]) begin
          regs[r] <= wr_win[r];
        end
      end
      // A reservation belongs to a younger producer, so it beats write-back.
      pending      <= res_hit | (pending & ~wr_hit);
      collision_p1 <= |wr_multi;
    end
  end

  always_comb begin
    rd_data_c = '0;
    rd_pend_c = '0;
    ra        = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra = bus.rd_addr[i*AW +: AW];
      rd_data_c[i*REG_WIDTH +: REG_WIDTH] = regs[ra];
      rd_pend_c[i] = pending[ra];
      if ((BYPASS != 0) && wr_hit[ra]) begin
        rd_data_c[i*REG_WIDTH +: REG_WIDTH] = wr_win[ra];
        if (!res_hit[ra]) begin
          rd_pend_c[i] = 1'b0;
        end
      end
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rd_data_c[i*REG_WIDTH +: REG_WIDTH] = '0;
        rd_pend_c[i] = 1'b0;
      end
    end
  end

  assign bus.rd_data      = rd_data_c;
  assign bus.rd_pending   = rd_pend_c;
  assign bus.wr_collision = collision_p1;
  assign bus.pending_any  = |pending;
endmodule

// File: tb/tb_cpu_bank_reg_mp.sv
// Bench for cpu_bank_reg_mp: a bypassing and a non-bypassing instance share
// stimulus; per-cycle vectors go through an expected-value queue.
module tb_cpu_bank_reg_mp;
  localparam int NUM_REGS  = 32;
  localparam int REG_WIDTH = 32;
  localparam int NUM_RD    = 2;
  localparam int NUM_WR    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_bank_reg_mp_if #(.NUM_REGS(NUM_REGS), .REG_WIDTH(REG_WIDTH),
                       .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus ();
  cpu_bank_reg_mp_if #(.NUM_REGS(NUM_REGS), .REG_WIDTH(REG_WIDTH),
                       .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus_nb ();

  assign bus_nb.rd_addr  = bus.rd_addr;
  assign bus_nb.wr_en    = bus.wr_en;
  assign bus_nb.wr_addr  = bus.wr_addr;
  assign bus_nb.wr_data  = bus.wr_data;
  assign bus_nb.res_en   = bus.res_en;
  assign bus_nb.res_addr = bus.res_addr;

  cpu_bank_reg_mp #(.NUM_REGS(NUM_REGS), .REG_WIDTH(REG_WIDTH), .NUM_RD(NUM_RD),
                    .NUM_WR(NUM_WR), .BYPASS(1), .ZERO_REG(1))
    u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  cpu_bank_reg_mp #(.NUM_REGS(NUM_REGS), .REG_WIDTH(REG_WIDTH), .NUM_RD(NUM_RD),
                    .NUM_WR(NUM_WR), .BYPASS(0), .ZERO_REG(1))
    u_dut_nb (.clk(clk), .rst_n(rst_n), .bus(bus_nb));

  typedef struct {
    string       name;
    logic [1:0]  wr_en;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        res_en;
    logic [4:0]  res_addr;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
    logic [1:0]  e_pend;
    logic        e_coll;
    logic        e_any;
    logic [31:0] e_nb_d1;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(string name, logic [1:0] wr_en,
                              logic [4:0] wa0, logic [31:0] wd0,
                              logic [4:0] wa1, logic [31:0] wd1,
                              logic res_en, logic [4:0] res_addr,
                              logic [4:0] ra0, logic [4:0] ra1,
                              logic [31:0] e_d0, logic [31:0] e_d1,
                              logic [1:0] e_pend, logic e_coll, logic e_any,
                              logic [31:0] e_nb_d1);
    vec_t v;
    v.name = name;     v.wr_en = wr_en;
    v.wa0 = wa0;       v.wd0 = wd0;       v.wa1 = wa1;   v.wd1 = wd1;
    v.res_en = res_en; v.res_addr = res_addr;
    v.ra0 = ra0;       v.ra1 = ra1;
    v.e_d0 = e_d0;     v.e_d1 = e_d1;     v.e_pend = e_pend;
    v.e_coll = e_coll; v.e_any = e_any;   v.e_nb_d1 = e_nb_d1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] wr_en, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic res_en, input logic [4:0] res_addr,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    bus.wr_en    = wr_en;
    bus.wr_addr  = {wa1, wa0};
    bus.wr_data  = {wd1, wd0};
    bus.res_en   = res_en;
    bus.res_addr = res_addr;
    bus.rd_addr  = {ra1, ra0};
  endtask

  task automatic check_outputs(input string name, input logic [31:0] d0, input logic [31:0] d1,
                               input logic [1:0] pend, input logic coll, input logic any,
                               input logic [31:0] nb_d1);
    chk({name, ".d0"},    bus.rd_data[31:0],            d0);
    chk({name, ".d1"},    bus.rd_data[63:32],           d1);
    chk({name, ".pend"},  32'(bus.rd_pending),          32'(pend));
    chk({name, ".coll"},  32'(bus.wr_collision),        32'(coll));
    chk({name, ".any"},   32'(bus.pending_any),         32'(any));
    chk({name, ".nb_d1"}, bus_nb.rd_data[63:32],        nb_d1);
  endtask

  // One vector per clock: drive after the edge, compare on the falling edge.
  task automatic run_vec(input vec_t v);
    vec_t e;
    drive(v.wr_en, v.wa0, v.wd0, v.wa1, v.wd1, v.res_en, v.res_addr, v.ra0, v.ra1);
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    check_outputs(e.name, e.e_d0, e.e_d1, e.e_pend, e.e_coll, e.e_any, e.e_nb_d1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs.push_back(mk("rst_rd",     2'b00, 0, 0, 0, 0, 0, 0, 5, 31,  0, 0, 2'b00, 0, 0, 0));
    vecs.push_back(mk("byp_wr",     2'b01, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 3,
                      0, 32'hDEADBEEF, 2'b00, 0, 0, 0));
    vecs.push_back(mk("wr_held",    2'b00, 0, 0, 0, 0, 0, 0, 3, 3,
                      32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0, 0, 32'hDEADBEEF));
    vecs.push_back(mk("coll_wr",    2'b11, 7, 32'h11, 7, 32'h22, 0, 0, 7, 7,
                      32'h22, 32'h22, 2'b00, 0, 0, 0));
    vecs.push_back(mk("coll_flag",  2'b11, 8, 32'h88, 9, 32'h99, 0, 0, 7, 9,
                      32'h22, 32'h99, 2'b00, 1, 0, 0));
    vecs.push_back(mk("coll_clr",   2'b00, 0, 0, 0, 0, 0, 0, 8, 9,
                      32'h88, 32'h99, 2'b00, 0, 0, 32'h99));
    vecs.push_back(mk("res10",      2'b00, 0, 0, 0, 0, 1, 10, 10, 10, 0, 0, 2'b00, 0, 0, 0));
    vecs.push_back(mk("pend10_a",   2'b00, 0, 0, 0, 0, 0, 0, 10, 10, 0, 0, 2'b11, 0, 1, 0));
    vecs.push_back(mk("pend10_b",   2'b00, 0, 0, 0, 0, 0, 0, 10, 10, 0, 0, 2'b11, 0, 1, 0));
    vecs.push_back(mk("pend10_c",   2'b00, 0, 0, 0, 0, 0, 0, 10, 10, 0, 0, 2'b11, 0, 1, 0));
    vecs.push_back(mk("wb10",       2'b10, 0, 0, 10, 32'h1234, 0, 0, 10, 10,
                      32'h1234, 32'h1234, 2'b00, 0, 1, 0));
    vecs.push_back(mk("wb10_done",  2'b00, 0, 0, 0, 0, 0, 0, 10, 10,
                      32'h1234, 32'h1234, 2'b00, 0, 0, 32'h1234));
    vecs.push_back(mk("race",       2'b10, 0, 0, 12, 32'h55, 1, 12, 12, 12,
                      32'h55, 32'h55, 2'b00, 0, 0, 0));
    vecs.push_back(mk("race_after", 2'b00, 0, 0, 0, 0, 0, 0, 12, 12,
                      32'h55, 32'h55, 2'b11, 0, 1, 32'h55));
    vecs.push_back(mk("zero_wr",    2'b01, 0, 32'hFF, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0));
    vecs.push_back(mk("zero_after", 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0));
    vecs.push_back(mk("zero_coll",  2'b11, 0, 32'hAA, 0, 32'hBB, 0, 0, 12, 0,
                      32'h55, 0, 2'b01, 0, 1, 0));
    vecs.push_back(mk("zero_coll2", 2'b00, 0, 0, 0, 0, 0, 0, 12, 12,
                      32'h55, 32'h55, 2'b11, 0, 1, 32'h55));

    drive(2'b00, 0, 0, 0, 0, 0, 0, 5, 31);
    #2;
    check_outputs("in_reset", 0, 0, 2'b00, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (vecs[k]) run_vec(vecs[k]);

    // Reserve and write r4 together, then drop reset between clock edges.
    drive(2'b01, 4, 32'h9, 0, 0, 1, 4, 4, 4);
    @(posedge clk);
    #1;
    drive(2'b00, 0, 0, 0, 0, 0, 0, 4, 4);
    #1;
    check_outputs("pre_arst", 32'h9, 32'h9, 2'b11, 0, 1, 32'h9);
    drive(2'b01, 4, 32'h77, 0, 0, 1, 6, 4, 4);
    #1;
    rst_n = 1'b0;
    #1;
    check_outputs("arst_now", 0, 0, 2'b00, 0, 0, 0);
    drive(2'b00, 0, 0, 0, 0, 0, 0, 4, 4);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_outputs("post_arst", 0, 0, 2'b00, 0, 0, 0);
    drive(2'b10, 0, 0, 4, 32'hABC, 0, 0, 4, 4);
    @(posedge clk);
    #1;
    drive(2'b00, 0, 0, 0, 0, 0, 0, 4, 4);
    #1;
    check_outputs("first_edge", 32'hABC, 32'hABC, 2'b00, 0, 0, 32'hABC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cpu_bank_reg_mp.md
Name: cpu_bank_reg_mp

Overview:
- Parametrised multi-port register bank. It is the next generation of the CPU register file, which had two read ports, one ALU write port and one MUL write port.
- Provides NUM_RD read ports and NUM_WR write ports, with a fixed write-priority rule and optional write-to-read bypass.
- Adds a per-register pending scoreboard: multi-cycle units (MUL, MEM) reserve a destination at issue, and decode sees the reservation until write-back.
- Sits between decode (read and reserve) and the write-back stages (one write port per producing unit).

Parameters:
- NUM_REGS, 32: number of architectural registers; must be a power of 2, at least 4.
- REG_WIDTH, 32: data width in bits.
- NUM_RD, 2: number of read ports, 1..4.
- NUM_WR, 2: number of write ports, 1..4. Port 0 is the ALU; higher ports are long-latency units.
- BYPASS, 1: 1 means a same-cycle write is forwarded to reads; 0 means reads return pre-edge array contents.
- ZERO_REG, 1: 1 means register 0 reads as 0 and ignores writes and reservations.
- AW (localparam), $clog2(NUM_REGS): register address width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- rd_addr  in  NUM_RD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NUM_RD*REG_WIDTH  read data, combinational.
- rd_pending  out  NUM_RD  1 when the addressed register has an outstanding reservation.
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*AW  per-port write address.
- wr_data  in  NUM_WR*REG_WIDTH  per-port write data.
- res_en  in  1  reserve request from decode.
- res_addr  in  AW  register to reserve.
- wr_collision  out  1  registered pulse: two or more enabled write ports targeted the same register in the previous cycle.
- pending_any  out  1  OR of all pending bits, registered state.

Behaviour:
- Reset, while rst_n=0, asynchronous: every register = 0, every pending bit = 0, wr_collision = 0. The reads below then return 0 with rd_pending = 0.
  - Reset asserted mid-operation discards all in-flight writes and reservations.
  - The first edge after rst_n rises is a normal cycle.
- Write:
  - On a rising edge, each port with wr_en=1 writes wr_data to wr_addr.
  - Same-address collision: the highest-indexed enabled port wins; lower ports targeting that address are dropped.
  - Writes to distinct addresses all commit in the same cycle.
- Collision flag: wr_collision <= 1 on the edge following any cycle with a same-address collision among enabled ports, else 0. Writes to register 0 with ZERO_REG=1 are excluded.
- Read, zero latency, combinational:
  - ZERO_REG=1 and rd_addr=0 gives 0.
  - Otherwise, if BYPASS=1 and any enabled port writes rd_addr this cycle, return the winning port's wr_data.
  - Otherwise return the stored value.
- Scoreboard, per register r, next-state priority:
  1. res_en && res_addr==r: pending <= 1. Reservation wins over a same-cycle write-back, because the new producer is younger.
  2. Else any wr_en && wr_addr==r: pending <= 0.
  3. Else hold.
  - A write from any port clears the bit; the ALU port may retire a register reserved by a long op only if the pipeline allows it, which is outside this block.
  - Reserving an already-pending register keeps it at 1; no counter is kept and no error is raised.
- rd_pending[i]: the pending bit of rd_addr[i].
  - With BYPASS=1 it is masked to 0 when a same-cycle write targets the register and no same-cycle reserve targets it.
  - It is always 0 for register 0 when ZERO_REG=1.
- pending_any is derived from the stored pending bits only; it is not bypassed.
- No X propagation: with all enables low, state holds indefinitely.

Test Plan:
- Reset then reads: rst_n=0 for 2 cycles, then read r5 and r31 -> rd_data=0, rd_pending=0, pending_any=0, wr_collision=0.
- Basic write and bypass: port0 writes r3=0xDEADBEEF while port1 reads r3.
  - BYPASS=1: 0xDEADBEEF in the same cycle.
  - BYPASS=0: old value 0 in that cycle, 0xDEADBEEF in the next.
- Collision: port0 writes r7=0x11 and port1 writes r7=0x22 in the same cycle -> next cycle r7 reads 0x22 and wr_collision=1 for exactly one cycle. Ports to distinct r8/r9 give wr_collision=0.
- Scoreboard lifecycle:
  - Reserve r10 -> rd_pending=1 and pending_any=1 from the next cycle.
  - 4 cycles later, port1 writes r10=0x1234 -> same-cycle rd_pending=0 (BYPASS=1), and the bit is stored clear afterwards.
- Reserve/write race: reserve r12 and port1 write r12=0x55 in the same cycle -> r12=0x55 and pending stays 1.
- Zero register and async reset: with ZERO_REG=1, write r0=0xFF and reserve r0 -> r0 reads 0 and rd_pending=0.
  - Then reserve r4 and write r4=0x9; drop rst_n mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
